// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/arb_grant.sv
// One-hot grant selection between two masters. The pointer names the
// favoured master; holding it at 0 yields fixed priority with m0 highest.
module arb_grant
  import mem_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] valid,
  input  logic                   ptr,
  output logic [NUM_MASTERS-1:0] grant
);

  // favoured master wins whenever it asks, otherwise the other one
  always_comb begin
    grant = '0;
    if (valid[ptr])       grant[ptr]  = 1'b1;
    else if (valid[~ptr]) grant[~ptr] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-memory arbiter, one transaction outstanding at a time.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; without
// it m0 has fixed priority and no pointer flop exists.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [31:0]   m0_data_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_req_valid_i,
  output logic          m0_req_ready_o,
  output logic [31:0]   m0_data_o,
  output logic          m0_rsp_valid_o,
  input  logic          m0_rsp_ready_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [31:0]   m1_data_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_req_valid_i,
  output logic          m1_req_ready_o,
  output logic [31:0]   m1_data_o,
  output logic          m1_rsp_valid_o,
  input  logic          m1_rsp_ready_i,
  output logic [AW-1:0] s_addr_o,
  output logic [31:0]   s_data_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_req_valid_o,
  input  logic          s_req_ready_i,
  input  logic [31:0]   s_data_i,
  input  logic          s_rsp_valid_i,
  output logic          s_rsp_ready_o
);

  logic [NUM_MASTERS-1:0][AW-1:0] m_addr;
  logic [NUM_MASTERS-1:0][31:0]   m_wdata;
  logic [NUM_MASTERS-1:0][3:0]    m_sel;
  logic [NUM_MASTERS-1:0]         m_we, m_vld, m_rsp_rdy;

  assign m_addr    = {m1_addr_i, m0_addr_i};
  assign m_wdata   = {m1_data_i, m0_data_i};
  assign m_sel     = {m1_sel_i, m0_sel_i};
  assign m_we      = {m1_we_i, m0_we_i};
  assign m_vld     = {m1_req_valid_i, m0_req_valid_i};
  assign m_rsp_rdy = {m1_rsp_ready_i, m0_rsp_ready_i};

  state_e                       st, st_nxt;
  logic [NUM_MASTERS-1:0]       owner, owner_nxt;
  logic [NUM_MASTERS-1:0]       grant, req_rdy, rsp_vld;
  logic [NUM_MASTERS-1:0][31:0] rsp_data;
  logic                         ptr;
  logic                         req_hs;

  // request accepted by memory this cycle
  assign req_hs = (st == ST_IDLE) && (|grant) && s_req_ready_i;

`ifdef MEM_ARB_RR_EN
  // favour the master that was not granted on the last accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (req_hs) ptr <= grant[0];
  end
`else
  assign ptr = 1'b0;
`endif

  arb_grant u_grant (
    .valid (m_vld),
    .ptr   (ptr),
    .grant (grant)
  );

  // FSM state and owning master
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      owner <= '0;
    end else begin
      st    <= st_nxt;
      owner <= owner_nxt;
    end
  end

  // next state, request mux in IDLE, response routing in WAIT
  always_comb begin
    st_nxt        = st;
    owner_nxt     = owner;
    s_addr_o      = '0;
    s_data_o      = '0;
    s_sel_o       = '0;
    s_we_o        = 1'b0;
    s_req_valid_o = 1'b0;
    s_rsp_ready_o = 1'b0;
    req_rdy       = '0;
    rsp_vld       = '0;
    rsp_data      = '0;
    case (st)
      ST_IDLE: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant[i]) begin
            s_addr_o      = m_addr[i];
            s_data_o      = m_wdata[i];
            s_sel_o       = m_sel[i];
            s_we_o        = m_we[i];
            s_req_valid_o = 1'b1;
            req_rdy[i]    = s_req_ready_i;
          end
        end
        if (req_hs) begin
          st_nxt    = ST_WAIT;
          owner_nxt = grant;
        end
      end
      ST_WAIT: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (owner[i]) begin
            rsp_vld[i]    = s_rsp_valid_i;
            rsp_data[i]   = s_data_i;
            s_rsp_ready_o = m_rsp_rdy[i];
          end
        end
        if (s_rsp_valid_i && (|(owner & m_rsp_rdy))) begin
          st_nxt    = ST_IDLE;
          owner_nxt = '0;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign m0_req_ready_o = req_rdy[0];
  assign m1_req_ready_o = req_rdy[1];
  assign m0_rsp_valid_o = rsp_vld[0];
  assign m1_rsp_valid_o = rsp_vld[1];
  assign m0_data_o      = rsp_data[0];
  assign m1_data_o      = rsp_data[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: masters push expected read data when
// they issue; a negedge monitor checks every cycle against a small model of
// the arbitration rules and pops expectations on each response handshake.
module tb_mem_arbiter;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] m_addr;
  logic [1:0][31:0]   m_wdata;
  logic [1:0][3:0]    m_sel;
  logic [1:0]         m_we, m_vld, m_rrdy;
  logic [1:0]         q_req_rdy, q_rsp_vld;
  logic [1:0][31:0]   q_data;
  logic [AW-1:0]      s_addr_o;
  logic [31:0]        s_data_o;
  logic [3:0]         s_sel_o;
  logic               s_we_o, s_req_valid_o, s_rsp_ready_o;
  logic               s_req_ready, s_rsp_valid;
  logic [31:0]        s_rdata;

  mem_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_wdata[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_req_valid_i(m_vld[0]), .m0_req_ready_o(q_req_rdy[0]), .m0_data_o(q_data[0]),
    .m0_rsp_valid_o(q_rsp_vld[0]), .m0_rsp_ready_i(m_rrdy[0]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_wdata[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_req_valid_i(m_vld[1]), .m1_req_ready_o(q_req_rdy[1]), .m1_data_o(q_data[1]),
    .m1_rsp_valid_o(q_rsp_vld[1]), .m1_rsp_ready_i(m_rrdy[1]),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready),
    .s_data_i(s_rdata), .s_rsp_valid_i(s_rsp_valid), .s_rsp_ready_o(s_rsp_ready_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] model_mem [16];   // what memory should hold, word index = {master, word}
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          grant_log [$];
  bit          mb_busy = 0;      // a transaction is outstanding
  int          mb_owner = 0;
  int          fav = 0;          // favoured master under round-robin

  function automatic int exp_winner();
    if (m_vld[0] && m_vld[1]) return fav;
    if (m_vld[0]) return 0;
    if (m_vld[1]) return 1;
    return -1;
  endfunction

  // ---------------- memory responder ----------------
  int          slv_rdy_mode = 1;   // 0 random, 1 high, 2 low
  int          slv_dmin = 0, slv_dmax = 0;
  logic [31:0] sim_mem [16];

  initial begin
    bit          hs_req, hs_rsp, busy, c_we;
    logic [AW-1:0] c_addr;
    logic [31:0] c_data, rdata;
    logic [3:0]  c_sel;
    int          dly;
    int          idx;
    busy = 0; dly = 0; rdata = '0;
    for (int i = 0; i < 16; i++) sim_mem[i] = '0;
    sim_mem[4] = 32'hDEADBEEF;
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      hs_req = s_req_valid_o && s_req_ready;
      hs_rsp = s_rsp_valid && s_rsp_ready_o;
      c_addr = s_addr_o; c_data = s_data_o; c_sel = s_sel_o; c_we = s_we_o;
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 0;
        s_rsp_valid = 1'b0;
      end else begin
        if (hs_rsp) begin s_rsp_valid = 1'b0; busy = 0; end
        if (hs_req) begin
          idx = int'(c_addr[5:2]);
          if (c_we)
            for (int b = 0; b < 4; b++) if (c_sel[b]) sim_mem[idx][8*b +: 8] = c_data[8*b +: 8];
          rdata = sim_mem[idx];
          busy = 1;
          dly = $urandom_range(slv_dmax, slv_dmin);
        end
        if (busy && !s_rsp_valid) begin
          if (dly == 0) begin s_rsp_valid = 1'b1; s_rdata = rdata; end
          else dly--;
        end
      end
      if (!s_rsp_valid) s_rdata = $urandom;
      s_req_ready = (slv_rdy_mode == 1) ? 1'b1 : (slv_rdy_mode == 2) ? 1'b0 : (($urandom % 3) != 0);
    end
  end

  // ---------------- master response-ready drivers ----------------
  int rr_mode [2] = '{1, 1};   // 0 random, 1 high, 2 low
  initial begin
    m_rrdy = 2'b00;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        m_rrdy[i] = (rr_mode[i] == 1) ? 1'b1 : (rr_mode[i] == 2) ? 1'b0 : (($urandom % 4) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int          w, o, n;
    logic [1:0]  exp_rdy;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mb_busy = 0; fav = 0;
        exp_q0.delete(); exp_q1.delete();
        chk("rst_s_out", {s_addr_o, s_data_o, s_sel_o, s_we_o, s_req_valid_o, s_rsp_ready_o}, '0);
        chk("rst_m_out", {q_req_rdy, q_rsp_vld, q_data}, '0);
      end else if (!mb_busy) begin
        w = exp_winner();
        chk("idle_rsp", {q_rsp_vld, q_data, s_rsp_ready_o}, '0);
        if (w < 0) begin
          chk("idle_noreq", {s_addr_o, s_data_o, s_sel_o, s_we_o, s_req_valid_o, q_req_rdy}, '0);
        end else begin
          exp_rdy = 2'b00;
          if (s_req_ready) exp_rdy[w] = 1'b1;
          chk("grant_payload", {s_addr_o, s_data_o, s_sel_o, s_we_o},
              {m_addr[w], m_wdata[w], m_sel[w], m_we[w]});
          chk("grant_ctrl", {s_req_valid_o, q_req_rdy}, {1'b1, exp_rdy});
          if (s_req_valid_o && s_req_ready) begin
            grant_log.push_back(q_req_rdy[1] ? 1 : 0);
            mb_busy = 1;
            mb_owner = w;
`ifdef MEM_ARB_RR_EN
            fav = 1 - w;
`endif
          end
        end
      end else begin
        o = mb_owner; n = 1 - o;
        chk("wait_req", {s_req_valid_o, q_req_rdy}, '0);
        chk("rsp_owner", {q_rsp_vld[o], q_data[o], s_rsp_ready_o}, {s_rsp_valid, s_rdata, m_rrdy[o]});
        chk("rsp_other", {q_rsp_vld[n], q_data[n]}, '0);
        if (s_rsp_valid && m_rrdy[o]) begin
          if ((o == 0 && exp_q0.size() == 0) || (o == 1 && exp_q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: master %0d got %h with nothing expected", o, q_data[o]);
          end else begin
            e = (o == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk(o == 0 ? "rsp_data_m0" : "rsp_data_m1", q_data[o], e);
          end
          mb_busy = 0;
        end
      end
    end
  end

  // ---------------- master tasks ----------------
  // Issue one request from master idx to word w of its own region and hold it until accepted.
  task automatic m_issue(input int idx, input int w, input bit we, input logic [31:0] d, input logic [3:0] sel);
    int  i;
    bit  ok;
    i = idx * 8 + w;
    if (we)
      for (int b = 0; b < 4; b++) if (sel[b]) model_mem[i][8*b +: 8] = d[8*b +: 8];
    if (idx == 0) exp_q0.push_back(model_mem[i]); else exp_q1.push_back(model_mem[i]);
    m_addr[idx] = AW'(i * 4); m_wdata[idx] = d; m_sel[idx] = sel; m_we[idx] = we;
    m_vld[idx] = 1'b1;
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (q_req_rdy[idx]) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_timeout: master %0d never accepted", idx);
      if (idx == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
    end
    @(posedge clk); #1;
    m_vld[idx] = 1'b0;
  endtask

  task automatic m_run(input int idx, input int cnt, input int gapmax);
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); #1; end
      m_issue(idx, $urandom_range(7, 0), 1'($urandom), $urandom, 4'($urandom));
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (!mb_busy && exp_q0.size() == 0 && exp_q1.size() == 0 && m_vld == 2'b00) ok = 1;
    end
    chk(name, ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  exp_order [6];
    bit  acc1, seen;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_mem[4] = 32'hDEADBEEF;
    m_addr = '0; m_wdata = '0; m_sel = '0; m_we = '0; m_vld = '0;

    // reset held for a few cycles; the monitor checks outputs meanwhile
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // m0 read of 0x10 with a one-cycle memory
    slv_rdy_mode = 1; slv_dmin = 0; slv_dmax = 0;
    @(posedge clk); #1;
    fork
      m_issue(0, 4, 1'b0, 32'h0, 4'hF);
      begin
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); if (q_req_rdy[0]) seen = 1; end
        chk("s1_accept", seen, 1'b1);
        @(negedge clk);
        chk("s1_rsp", {q_rsp_vld, q_data[0], q_data[1]}, {2'b01, 32'hDEADBEEF, 32'h0});
      end
    join
    wait_idle("s1_idle");

    // m0 write held while memory is not ready
    slv_rdy_mode = 2;
    @(posedge clk); #1;
    fork
      m_issue(0, 3, 1'b1, 32'h12345678, 4'hF);
      begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("s4_hold", {s_addr_o, s_data_o, s_sel_o, s_we_o, s_req_valid_o, q_req_rdy},
              {32'h0000000C, 32'h12345678, 4'hF, 1'b1, 1'b1, 2'b00});
        end
        @(posedge clk); #1;
        slv_rdy_mode = 1;
      end
    join
    wait_idle("s4_idle");

    // m1 response back-pressured for three cycles while m0 waits
    rr_mode[1] = 2;
    acc1 = 0;
    @(posedge clk); #1;
    fork
      m_issue(1, 2, 1'b0, 32'h0, 4'hF);
      begin
        for (int k = 0; k < 100 && !acc1; k++) begin @(posedge clk); #1; end
        m_issue(0, 1, 1'b0, 32'h0, 4'h3);
      end
      begin
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); if (q_req_rdy[1]) seen = 1; end
        chk("s3_accept", seen, 1'b1);
        @(posedge clk); #1;
        acc1 = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("s3_stall", {s_rsp_ready_o, q_rsp_vld, s_req_valid_o, q_req_rdy},
              {1'b0, 2'b10, 1'b0, 2'b00});
        end
        @(posedge clk); #1;
        rr_mode[1] = 1;
      end
    join
    wait_idle("s3_idle");

    // reset while a response is still pending in memory
    slv_dmin = 5; slv_dmax = 5;
    m_issue(0, 2, 1'b0, 32'h0, 4'hF);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_s", {s_addr_o, s_data_o, s_sel_o, s_we_o, s_req_valid_o, s_rsp_ready_o}, '0);
    chk("s6_rst_m", {q_req_rdy, q_rsp_vld, q_data}, '0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    slv_dmin = 0; slv_dmax = 0;
    @(negedge clk);
    chk("s6_post_idle", {s_req_valid_o, q_req_rdy, q_rsp_vld, s_rsp_ready_o}, '0);
    @(posedge clk); #1;
    m_issue(1, 6, 1'b0, 32'h0, 4'hF);
    wait_idle("s6_idle");

    // simultaneous, continuously held requests straight from reset
    do_reset();
    grant_log.delete();
    slv_dmin = 0; slv_dmax = 1;
    rr_mode[0] = 0; rr_mode[1] = 0;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 0};
`else
    exp_order = '{0, 0, 0, 0, 1, 1};
`endif
    fork
      m_run(0, 4, 0);
      m_run(1, 2, 0);
    join
    wait_idle("s2_idle");
    chk("s2_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk($sformatf("s2_order_%0d", k), grant_log[k], exp_order[k]);

    // random traffic on both masters with random memory timing
    slv_rdy_mode = 0; slv_dmin = 0; slv_dmax = 3;
    fork
      m_run(0, 30, 3);
      m_run(1, 30, 3);
    join
    wait_idle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
